// File: rtl/bcd12_uart_tx.sv
// Sends a latched 3-digit BCD value as three 8N1 UART frames, least-significant digit first.
// Each byte is {HI_NIBBLE, digit}, so with the default HI_NIBBLE a valid digit is its ASCII code.
module bcd12_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [3:0]  HI_NIBBLE    = 4'h3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] data12,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e            state;
    logic [TimerW-1:0] bit_timer;
    logic [2:0]        bit_idx;
    logic [1:0]        byte_idx;
    logic [11:0]       data_q;
    logic [7:0]        shift_reg;
    logic [3:0]        next_digit;

    // Digit for the byte that follows the one now finishing its stop bit.
    always_comb begin
        next_digit = data_q[11:8];
        if (byte_idx == 2'd0) begin
            next_digit = data_q[7:4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            bit_timer <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            data_q    <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (start) begin
                        data_q    <= data12;
                        shift_reg <= {HI_NIBBLE, data12[3:0]};
                        byte_idx  <= '0;
                        bit_timer <= '0;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                        state     <= StStart;
                    end
                end
                StStart: begin
                    if (bit_timer == TimerMax) begin
                        bit_timer <= '0;
                        bit_idx   <= '0;
                        tx        <= shift_reg[0];
                        state     <= StData;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                StData: begin
                    if (bit_timer == TimerMax) begin
                        bit_timer <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= StStop;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                StStop: begin
                    if (bit_timer == TimerMax) begin
                        bit_timer <= '0;
                        if (byte_idx == 2'd2) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            // Next frame starts immediately, no idle gap between bytes.
                            byte_idx  <= byte_idx + 1'b1;
                            shift_reg <= {HI_NIBBLE, next_digit};
                            tx        <= 1'b0;
                            state     <= StStart;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd12_uart_tx.sv
// Bench for bcd12_uart_tx: a serial monitor decodes tx frames and checks them against a
// queue of expected bytes; transfer timing and corner sequences are checked directly.
module tb_bcd12_uart_tx;

    localparam int unsigned Cpb = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [11:0] data12 = '0;
    logic        tx_a, busy_a, done_a;
    logic        tx_b, busy_b, done_b;
    logic        sel = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    bcd12_uart_tx #(.CLKS_PER_BIT(Cpb), .HI_NIBBLE(4'h3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .data12(data12),
        .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    bcd12_uart_tx #(.CLKS_PER_BIT(Cpb), .HI_NIBBLE(4'h0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .data12(data12),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    wire tx_m   = sel ? tx_b   : tx_a;
    wire busy_m = sel ? busy_b : busy_a;
    wire done_m = sel ? done_b : done_a;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Serial monitor: every bit must hold for exactly Cpb cycles.
    initial begin
        logic [9:0] bits;
        bit ok, aborted;
        forever begin
            @(negedge clk);
            if (rst_n && tx_m === 1'b0) begin
                ok = 1'b1;
                aborted = 1'b0;
                bits = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int s = 0; s < int'(Cpb) && !aborted; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (!rst_n) aborted = 1'b1;
                        else if (s == 0) bits[b] = tx_m;
                        else if (tx_m !== bits[b]) ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    check("frame_bit_timing", int'(ok), 1);
                    check("frame_start_bit", int'(bits[0]), 0);
                    check("frame_stop_bit", int'(bits[9]), 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", int'(bits[8:1]), -1);
                    end else begin
                        check("rx_byte", int'(bits[8:1]), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // Wait for done; counts busy-high negedges and negedges until done is seen.
    task automatic wait_done(output int busy_n, output int lat);
        busy_n = 0;
        lat = 0;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            if (done_m) break;
            if (busy_m) busy_n++;
        end
        if (!done_m) check("done_timeout", 0, 1);
    endtask

    task automatic pulse_start(input logic [11:0] d);
        data12 = d;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    typedef struct {
        logic [11:0] data;
        bit          use_b;
        logic [7:0]  b0, b1, b2;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int busy_n, lat, lows, dones;

        vecs[0] = '{12'h395, 1'b0, 8'h35, 8'h39, 8'h33};
        vecs[1] = '{12'h000, 1'b0, 8'h30, 8'h30, 8'h30};
        vecs[2] = '{12'h999, 1'b0, 8'h39, 8'h39, 8'h39};
        vecs[3] = '{12'h407, 1'b0, 8'h37, 8'h30, 8'h34};
        vecs[4] = '{12'hFA0, 1'b1, 8'h00, 8'h0A, 8'h0F};
        vecs[5] = '{12'hFA0, 1'b0, 8'h30, 8'h3A, 8'h3F};

        #12;
        check("reset_tx", int'(tx_a), 1);
        check("reset_busy", int'(busy_a), 0);
        check("reset_done", int'(done_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].use_b;
            @(negedge clk);
            exp_q.push_back(vecs[i].b0);
            exp_q.push_back(vecs[i].b1);
            exp_q.push_back(vecs[i].b2);
            pulse_start(vecs[i].data);
            @(negedge clk);
            check("tx_low_after_accept", int'(tx_m), 0);
            check("busy_after_accept", int'(busy_m), 1);
            wait_done(busy_n, lat);
            check("busy_cycles", busy_n + 1, 30 * Cpb);
            check("done_latency", lat + 1, 30 * Cpb + 1);
            @(negedge clk);
            check("done_one_cycle", int'(done_m), 0);
            repeat (3) @(negedge clk);
            check("queue_drained", exp_q.size(), 0);
        end
        sel = 1'b0;

        // Mid-transfer start and data change must be ignored.
        @(negedge clk);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h31);
        pulse_start(12'h123);
        repeat (50) @(negedge clk);
        pulse_start(12'h456);
        wait_done(busy_n, lat);
        dones = 0;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (done_a) dones++;
            if (!tx_a) lows++;
        end
        check("ignored_start_no_done", dones, 0);
        check("ignored_start_no_tx", lows, 0);
        check("ignored_queue", exp_q.size(), 0);

        // Back-to-back: start asserted in the done cycle.
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h31);
        pulse_start(12'h123);
        wait_done(busy_n, lat);
        check("b2b_idle_cycle_tx", int'(tx_a), 1);
        exp_q.push_back(8'h38);
        exp_q.push_back(8'h38);
        exp_q.push_back(8'h38);
        pulse_start(12'h888);
        @(negedge clk);
        check("b2b_tx_low", int'(tx_a), 0);
        wait_done(busy_n, lat);
        check("b2b_busy_cycles", busy_n + 1, 30 * Cpb);
        repeat (3) @(negedge clk);
        check("b2b_queue", exp_q.size(), 0);

        // Asynchronous reset mid-frame abandons the transfer.
        pulse_start(12'h777);
        repeat (30) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_tx", int'(tx_a), 1);
        check("midreset_busy", int'(busy_a), 0);
        check("midreset_done", int'(done_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (!tx_a || busy_a || done_a) lows++;
        end
        check("post_reset_idle", lows, 0);
        check("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd12_uart_tx.md
# bcd12_uart_tx

Transmit-side counterpart of the 3-digit BCD UART receiver. Latches a 12-bit value holding three BCD digits and sends it as three 8N1 UART frames, least-significant digit first. Each byte carries one digit in its low nibble, which is where the receiver collects it. Sits between the local data source (display/counter logic) and the board TX pin.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range ≥ 2
- HI_NIBBLE, 4'h3, constant upper nibble of every byte (4'h3 makes valid digits ASCII '0'–'9')

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request to send; sampled on the rising edge of clk
- data12  in  12  digits: [3:0] d0, [7:4] d1, [11:8] d2
- tx  out  1  UART serial line; idles high
- busy  out  1  high from the cycle after acceptance until the last stop bit ends
- done  out  1  one-cycle pulse when the transfer completes

## Operation
- States:
  - IDLE: tx=1, busy=0.
  - START: tx=0.
  - DATA: tx = shift_reg[0], sent LSB first, 8 bits.
  - STOP: tx=1.
- Counters:
  - bit-timer 0..CLKS_PER_BIT-1
  - bit index 0..7
  - byte index 0..2
- Acceptance: in IDLE with start=1, data12 is latched into an internal register. Byte index is set to 0 and the state goes to START. busy rises on the same edge.
- start while busy=1 is ignored and not queued. data12 changes after acceptance have no effect.
- Byte k is {HI_NIBBLE, digit_k}: byte 0 = {HI_NIBBLE, data12[3:0]}, byte 1 = {HI_NIBBLE, data12[7:4]}, byte 2 = {HI_NIBBLE, data12[11:8]}.
- Non-BCD nibbles (A–F) are transmitted unchanged; there is no checking or saturation.
- Each state holds for exactly CLKS_PER_BIT cycles. START→DATA; DATA stays for 8 bit periods, then goes to STOP.
- End of STOP period:
  - byte index < 2: increment it and go to START with no idle gap.
  - byte index = 2: go to IDLE, busy goes low, done pulses.
- Frame format: 1 start bit, 8 data bits, no parity, 1 stop bit.

## Timing
- Reset (rst_n=0, asynchronous): tx=1, busy=0, done=0, state=IDLE, all counters 0, latched data cleared. This takes effect immediately, including mid-frame; a partial frame is abandoned.
- Leaving reset: the block is in IDLE. The first start is accepted on the first rising edge with rst_n=1.
- Latency:
  - tx falls 1 clk after the accepting edge; this is the first start-bit cycle.
  - Each bit occupies exactly CLKS_PER_BIT cycles.
  - Whole transfer: 30·CLKS_PER_BIT cycles from first tx low to the end of the final stop bit.
- done goes high for exactly 1 cycle, on the edge that ends the final stop bit. busy falls on that same edge.
- Back-to-back: start=1 in the same cycle done=1 is accepted, since the block is already in IDLE on that edge. The new transfer's tx low follows 1 clk later, so the gap between transfers is 1 idle-high cycle at most.
- start held high continuously: transfers repeat with that same 1-cycle gap.
- All outputs are registered; tx is glitch-free.

## Test plan
- Reset values: assert rst_n=0 mid-operation → tx=1, busy=0, done=0 within the same cycle. Release reset → tx stays high indefinitely with start=0.
- Single transfer, CLKS_PER_BIT=4, data12=12'h395, 1-cycle start pulse:
  - tx decodes to bytes 0x35, 0x39, 0x33 in that order, each with start bit 0 and stop bit 1, 4 cycles per bit.
  - busy high for 120 cycles.
  - done pulses once, 121 cycles after acceptance.
- Loopback: CLKS_PER_BIT matched to the existing receiver; send 12'h000, 12'h999, 12'h407 → receiver data12 output equals each sent value.
- Ignored start and input change: pulse start with 12'h123; mid-transfer, pulse start again and change data12 to 12'h456 → exactly 3 bytes sent (0x33, 0x32, 0x31) and a single done pulse.
- Back-to-back: start asserted on the done cycle with data12=12'h888 → next frame starts after 1 idle cycle and sends 0x38 ×3.
- Non-BCD digits and HI_NIBBLE: HI_NIBBLE=4'h0, data12=12'hFA0 → bytes 0x00, 0x0A, 0x0F.
